vc_dispatch: RTL and testbench
==============================

# vc_dispatch

Parametrised dispatcher between the main FIFO and the per-virtual-channel FIFOs of the transmit path. It issues `pop_main_fifo` when flow control permits, captures the word returned one cycle later, and decodes its destination VC from the top bits. It holds the word in a 2-entry skid buffer and pushes it into the selected VC FIFO. It generalises the two-channel pop/valid logic to `NUM_VC` channels, adds a selective-pause mode, full throughput under back-pressure, and drop/dispatch counters.

## Interface
- `DATA_W`, 10: word width; the destination field is bits `[DATA_W-1 -: SEL_W]`.
- `NUM_VC`, 2: number of virtual channels, 2..8.
- `SEL_W`, `$clog2(NUM_VC)`: width of the destination field.
- `MODE`, 0: 0 = global pause (any `pause_vc` stalls everything), 1 = selective (only the head word's destination matters).
- `CNT_W`, 8: width of the status counters.

Ports (name, direction, width, meaning):
- `clk`, in, 1: single clock, rising edge.
- `reset`, in, 1: asynchronous, active-low.
- `pause_vc`, in, `NUM_VC`: per-VC almost-full/pause.
- `empty_main_fifo`, in, 1: main FIFO empty.
- `data_main_fifo`, in, `DATA_W`: main FIFO read data, valid the cycle after a pop.
- `pop_main_fifo`, out, 1: main FIFO read enable (combinational).
- `valid_pop_out`, out, 1: registered copy of `pop_main_fifo`; marks a word in flight.
- `push_vc`, out, `NUM_VC`: one-hot write enable to the VC FIFOs.
- `data_vc`, out, `DATA_W`: write data shared by all VC FIFOs.
- `dispatch_count`, out, `CNT_W`: words pushed, saturating.
- `drop_count`, out, `CNT_W`: words dropped for an invalid destination, saturating.

## Operation
- `reset`=0: `pop_main_fifo`=0 combinationally. `valid_pop_out`, `push_vc`, `dispatch_count`, `drop_count` and skid occupancy are all 0. `data_vc` is 0.
- Skid occupancy `occ` ranges 0..2. `inflight` = `valid_pop_out`.
- Head word: `dest` = the head word's top `SEL_W` bits.
  - Invalid if `dest >= NUM_VC`. An invalid head is discarded in one cycle (`drain`=1, no push) and increments `drop_count`.
- `drain` for a valid head:
  - MODE 0: `occ>0 && !(|pause_vc)`.
  - MODE 1: `occ>0 && !pause_vc[dest]`.
- Push: on `drain` of a valid head, `push_vc[dest]`=1, `data_vc` = head data, `dispatch_count` increments.
- Pop: `pop_main_fifo` = `reset && !empty_main_fifo && gate && (occ + inflight - drain) < 2`.
  - `gate` = `!(|pause_vc)` in MODE 0; `gate` = 1 in MODE 1.
- Capture: when `inflight`=1, `data_main_fifo` is written into the skid tail in the same cycle.
- Simultaneous capture and drain: occupancy is unchanged and order is preserved (FIFO).
- Pop credit guarantees that a capture never overflows the skid buffer. Overflow is an assertion failure.
- Counters saturate at all-ones and never wrap.

## Timing
- Pop at cycle t → `valid_pop_out`=1 at t+1 → word enters skid at end of t+1 → earliest push at t+2.
- Pop-to-push latency is 2 cycles with no pause.
- Throughput with no pause is 1 word/cycle in steady state (`occ`=1, `inflight`=1, `drain`=1).
- Pause asserted at t:
  - No push to the affected VC at t (combinational).
  - Words already popped are absorbed by the skid buffer; no word is lost.
- Reset asserted mid-operation: the skid buffer contents and the in-flight word are discarded; outputs go to reset values immediately (async).
- `push_vc`, `data_vc` and `pop_main_fifo` are combinational from registered state plus `pause_vc`/`empty_main_fifo`. There is no combinational path from `data_main_fifo` to any output.

## Structure
- Package `vc_dispatch_pkg`:
  - `MODE_GLOBAL`=0, `MODE_SELECTIVE`=1.
  - Function `dest_of(word)` extracting the destination field.
- Sub-module `dispatch_skid`: 2-entry synchronous FIFO with `wr`, `rd`, `occ`, `head` and async active-low reset.
- Top level: pop credit logic, destination decode, one-hot push, counters.

## Test plan
- NUM_VC=4, MODE=0, no pause, main FIFO holds 0x000, 0x100, 0x200, 0x300 (DATA_W=10):
  - Pops on 4 consecutive cycles.
  - `push_vc` = 0001, 0010, 0100, 1000 on cycles 2..5.
  - `dispatch_count`=4.
- MODE=0, `pause_vc[3]` raised while streaming: `pop_main_fifo` drops the same cycle; the at most 2 words already popped stay in the skid buffer; on pause release they are pushed in order with no loss or duplication.
- MODE=1, `pause_vc`=0010, stream alternating dest 0 and 2: all words pushed with no stall; `pop_main_fifo` stays high while the main FIFO is non-empty.
- MODE=1, head word has dest 1 and `pause_vc[1]`=1:
  - Head-of-line block: `occ` reaches 2, pops stop.
  - After release, 2 pushes on consecutive cycles.
- NUM_VC=3, word with dest=3: no push, `drop_count`=1, and the following word with dest 0 is pushed the next cycle.
- `reset` pulled low with `occ`=2 and `inflight`=1:
  - All outputs are 0 immediately.
  - After release, the next word popped is the first word pushed.
  - The counters restart from 0.

Source files
------------

// File: rtl/vc_dispatch_pkg.sv
// Shared constants and helpers for the VC dispatcher.
//   MODE_GLOBAL / MODE_SELECTIVE : pause-mode encodings for vc_dispatch.MODE
//   dest_of()                    : extracts the destination VC field from a word
package vc_dispatch_pkg;

  localparam int unsigned MODE_GLOBAL    = 0;
  localparam int unsigned MODE_SELECTIVE = 1;

  // Widest word and destination field the helper handles (NUM_VC <= 8).
  localparam int unsigned MAX_DATA_W = 64;
  localparam int unsigned MAX_SEL_W  = 3;

  // Top sel_w bits of a data_w-bit word (word is zero-extended to MAX_DATA_W).
  function automatic logic [MAX_SEL_W-1:0] dest_of(
    input logic [MAX_DATA_W-1:0] word,
    input int unsigned           data_w,
    input int unsigned           sel_w
  );
    logic [MAX_DATA_W-1:0] mask;
    mask = (MAX_DATA_W'(1) << sel_w) - MAX_DATA_W'(1);
    return MAX_SEL_W'((word >> (data_w - sel_w)) & mask);
  endfunction

endpackage

// File: rtl/vc_dispatch_skid.sv
// Two-entry synchronous FIFO holding words returned by the main FIFO until
// they can be pushed into a VC FIFO.
//   clk, rst_n   : clock, asynchronous active-low reset (clears contents)
//   wr, wr_data  : write the tail
//   rd           : discard the head
//   occ          : number of valid entries (0..2)
//   head         : oldest entry
module dispatch_skid #(
  parameter int unsigned W = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         wr,
  input  logic [W-1:0] wr_data,
  input  logic         rd,
  output logic [1:0]   occ,
  output logic [W-1:0] head
);

  logic [W-1:0] mem_q [2];
  logic         wr_ptr_q;
  logic         rd_ptr_q;
  logic [1:0]   occ_q;
  logic [1:0]   occ_d;

  // Occupancy only moves when exactly one of write/read happens.
  always_comb begin
    occ_d = occ_q;
    if (wr && !rd) begin
      occ_d = occ_q + 2'd1;
    end else if (!wr && rd) begin
      occ_d = occ_q - 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      occ_q    <= 2'd0;
    end else begin
      if (wr) begin
        mem_q[wr_ptr_q] <= wr_data;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (rd) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      occ_q <= occ_d;
    end
  end

  assign occ  = occ_q;
  assign head = mem_q[rd_ptr_q];

  // Pop credit upstream must keep both of these from ever happening.
  ap_no_overflow : assert property (@(posedge clk) disable iff (!rst_n)
    !(wr && !rd && (occ_q == 2'd2)));
  ap_no_underflow : assert property (@(posedge clk) disable iff (!rst_n)
    !(rd && (occ_q == 2'd0)));

endmodule

// File: rtl/vc_dispatch.sv
// Dispatcher from the main FIFO to NUM_VC per-channel FIFOs.
// Pops the main FIFO under credit/pause control, captures the returned word
// into a 2-entry skid buffer, decodes the destination from the top SEL_W bits
// and pushes it one-hot into the selected VC FIFO.
//   clk, reset       : clock, asynchronous active-low reset
//   pause_vc         : per-VC pause / almost-full
//   empty_main_fifo  : main FIFO empty
//   data_main_fifo   : main FIFO read data (valid the cycle after a pop)
//   pop_main_fifo    : main FIFO read enable (combinational)
//   valid_pop_out    : registered pop, marks the word in flight
//   push_vc, data_vc : one-hot VC FIFO write enable and shared write data
//   dispatch_count   : saturating count of pushed words
//   drop_count       : saturating count of words with an invalid destination
module vc_dispatch
  import vc_dispatch_pkg::*;
#(
  parameter int unsigned DATA_W = 10,
  parameter int unsigned NUM_VC = 2,
  parameter int unsigned SEL_W  = $clog2(NUM_VC),
  parameter int unsigned MODE   = 0,
  parameter int unsigned CNT_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_VC-1:0] pause_vc,
  input  logic              empty_main_fifo,
  input  logic [DATA_W-1:0] data_main_fifo,
  output logic              pop_main_fifo,
  output logic              valid_pop_out,
  output logic [NUM_VC-1:0] push_vc,
  output logic [DATA_W-1:0] data_vc,
  output logic [CNT_W-1:0]  dispatch_count,
  output logic [CNT_W-1:0]  drop_count
);

  logic [1:0]           occ;
  logic [DATA_W-1:0]    head;
  logic [MAX_SEL_W-1:0] dest;
  logic                 dest_ok;
  logic [NUM_VC-1:0]    dest_oh;
  logic                 any_pause;
  logic                 head_paused;
  logic                 gate;
  logic                 drain;
  logic                 push;
  logic [2:0]           credit_used;

  logic                 valid_pop_q;
  logic [CNT_W-1:0]     disp_q, disp_d;
  logic [CNT_W-1:0]     drop_q, drop_d;

  // Head decode, drain decision, pop credit and one-hot push.
  always_comb begin
    dest        = dest_of(MAX_DATA_W'(head), DATA_W, SEL_W);
    dest_ok     = (32'(dest) < NUM_VC);
    dest_oh     = NUM_VC'(1) << dest;
    any_pause   = |pause_vc;
    head_paused = (MODE == MODE_SELECTIVE) ? |(pause_vc & dest_oh) : any_pause;
    // Invalid heads are discarded regardless of pause so they cannot block.
    drain       = (occ != 2'd0) && (!dest_ok || !head_paused);
    push        = drain && dest_ok;
    gate        = (MODE == MODE_SELECTIVE) ? 1'b1 : !any_pause;
    // Pop only if the word it returns is guaranteed a skid slot.
    credit_used = 3'(occ) + 3'(valid_pop_q);
    pop_main_fifo = reset && !empty_main_fifo && gate &&
                    (credit_used < (3'd2 + 3'(drain)));
    push_vc = push ? dest_oh : '0;
    data_vc = push ? head : '0;
  end

  // Saturating status counters.
  always_comb begin
    disp_d = disp_q;
    drop_d = drop_q;
    if (push && (disp_q != '1)) begin
      disp_d = disp_q + CNT_W'(1);
    end
    if (drain && !dest_ok && (drop_q != '1)) begin
      drop_d = drop_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_pop_q <= 1'b0;
      disp_q      <= '0;
      drop_q      <= '0;
    end else begin
      valid_pop_q <= pop_main_fifo;
      disp_q      <= disp_d;
      drop_q      <= drop_d;
    end
  end

  dispatch_skid #(
    .W (DATA_W)
  ) u_skid (
    .clk     (clk),
    .rst_n   (reset),
    .wr      (valid_pop_q),
    .wr_data (data_main_fifo),
    .rd      (drain),
    .occ     (occ),
    .head    (head)
  );

  assign valid_pop_out  = valid_pop_q;
  assign dispatch_count = disp_q;
  assign drop_count     = drop_q;

endmodule

// File: tb/tb_vc_dispatch.sv
// Bench for vc_dispatch: a global-pause and a selective-pause instance
// (NUM_VC=3, so destination 3 is invalid) driven from modelled main FIFOs and
// compared every cycle against a queue-level reference model.
module tb_vc_dispatch;

  localparam int unsigned DW     = 10;
  localparam int unsigned NV     = 3;
  localparam int unsigned CW     = 8;
  localparam int unsigned NI     = 2;
  localparam int unsigned QDEPTH = 8192;
  localparam int          CMAX   = 255;

  logic clk = 1'b0;
  logic reset;
  logic [NI-1:0][NV-1:0] pause_a;
  logic [NI-1:0]         empty_a;
  logic [NI-1:0][DW-1:0] mdata_a;

  logic          pop_g, pop_s, vpo_g, vpo_s;
  logic [NV-1:0] push_g, push_s;
  logic [DW-1:0] dvc_g, dvc_s;
  logic [CW-1:0] dc_g, dc_s, drc_g, drc_s;

  logic [NI-1:0]         pop_a, vpo_a;
  logic [NI-1:0][NV-1:0] push_a;
  logic [NI-1:0][DW-1:0] dvc_a;
  logic [NI-1:0][CW-1:0] dc_a, drc_a;

  assign pop_a  = {pop_s, pop_g};
  assign vpo_a  = {vpo_s, vpo_g};
  assign push_a = {push_s, push_g};
  assign dvc_a  = {dvc_s, dvc_g};
  assign dc_a   = {dc_s, dc_g};
  assign drc_a  = {drc_s, drc_g};

  always #5 clk = ~clk;

  vc_dispatch #(.DATA_W(DW), .NUM_VC(NV), .MODE(0), .CNT_W(CW)) u_glob (
    .clk(clk), .reset(reset), .pause_vc(pause_a[0]), .empty_main_fifo(empty_a[0]),
    .data_main_fifo(mdata_a[0]), .pop_main_fifo(pop_g), .valid_pop_out(vpo_g),
    .push_vc(push_g), .data_vc(dvc_g), .dispatch_count(dc_g), .drop_count(drc_g)
  );

  vc_dispatch #(.DATA_W(DW), .NUM_VC(NV), .MODE(1), .CNT_W(CW)) u_sel (
    .clk(clk), .reset(reset), .pause_vc(pause_a[1]), .empty_main_fifo(empty_a[1]),
    .data_main_fifo(mdata_a[1]), .pop_main_fifo(pop_s), .valid_pop_out(vpo_s),
    .push_vc(push_s), .data_vc(dvc_s), .dispatch_count(dc_s), .drop_count(drc_s)
  );

  // Reference model: main FIFO contents, words held after capture, word in flight.
  logic [DW-1:0] mq_mem [NI][QDEPTH];
  int            mq_rd  [NI];
  int            mq_wr  [NI];
  logic [DW-1:0] sk     [NI][4];
  int            sk_n   [NI];
  bit            infl   [NI];
  logic [DW-1:0] infl_w [NI];
  int            m_disp [NI];
  int            m_drop [NI];

  int n_chk;
  int n_pass;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic enqueue(input int i, input logic [DW-1:0] w);
    if (mq_wr[i] < QDEPTH) begin
      mq_mem[i][mq_wr[i]] = w;
      mq_wr[i]++;
    end
  endtask

  // One clock cycle: drive inputs, check outputs against the model, advance it.
  task automatic step();
    logic [DW-1:0] head;
    int unsigned   dest;
    bit            dvalid, anyp, drain, gate, epop;
    logic [NV-1:0] epush;
    string         nm;
    for (int i = 0; i < NI; i++) begin
      empty_a[i] = (mq_rd[i] == mq_wr[i]);
      mdata_a[i] = infl[i] ? infl_w[i] : DW'($urandom);
    end
    #2;
    for (int i = 0; i < NI; i++) begin
      nm     = (i == 0) ? "glob" : "sel";
      head   = sk[i][0];
      dest   = 32'(head[DW-1 -: 2]);
      dvalid = (dest < NV);
      anyp   = (pause_a[i] != '0);
      drain  = (sk_n[i] > 0) && (!dvalid || ((i == 0) ? !anyp : !pause_a[i][dest]));
      gate   = (i == 0) ? !anyp : 1'b1;
      epop   = !empty_a[i] && gate && ((sk_n[i] + int'(infl[i]) - int'(drain)) < 2);
      epush  = (drain && dvalid) ? NV'(1 << dest) : '0;
      check({nm, ".pop"},   32'(pop_a[i]),  32'(epop));
      check({nm, ".valid"}, 32'(vpo_a[i]),  32'(infl[i]));
      check({nm, ".push"},  32'(push_a[i]), 32'(epush));
      if (epush != '0) check({nm, ".data"}, 32'(dvc_a[i]), 32'(head));
      check({nm, ".disp"},  32'(dc_a[i]),   32'(m_disp[i]));
      check({nm, ".drop"},  32'(drc_a[i]),  32'(m_drop[i]));
      if (drain) begin
        for (int k = 0; k < 3; k++) sk[i][k] = sk[i][k+1];
        sk_n[i]--;
        if (dvalid) begin
          if (m_disp[i] < CMAX) m_disp[i]++;
        end else begin
          if (m_drop[i] < CMAX) m_drop[i]++;
        end
      end
      if (infl[i]) begin
        sk[i][sk_n[i]] = infl_w[i];
        sk_n[i]++;
      end
      infl[i] = epop;
      if (epop) begin
        infl_w[i] = mq_mem[i][mq_rd[i]];
        mq_rd[i]++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Asynchronous reset: outputs must clear at once; held words are lost.
  task automatic do_reset(input int hold);
    reset = 1'b0;
    #1;
    for (int i = 0; i < NI; i++) begin
      check("rst.pop",   32'(pop_a[i]),  32'd0);
      check("rst.valid", 32'(vpo_a[i]),  32'd0);
      check("rst.push",  32'(push_a[i]), 32'd0);
      check("rst.data",  32'(dvc_a[i]),  32'd0);
      check("rst.disp",  32'(dc_a[i]),   32'd0);
      check("rst.drop",  32'(drc_a[i]),  32'd0);
      sk_n[i]   = 0;
      infl[i]   = 1'b0;
      m_disp[i] = 0;
      m_drop[i] = 0;
    end
    repeat (hold) @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    logic [DW-1:0] w;
    n_chk   = 0;
    n_pass  = 0;
    pause_a = '0;
    empty_a = '1;
    mdata_a = '0;
    for (int i = 0; i < NI; i++) begin
      mq_rd[i] = 0; mq_wr[i] = 0; sk_n[i] = 0; infl[i] = 1'b0;
      infl_w[i] = '0; m_disp[i] = 0; m_drop[i] = 0;
      for (int k = 0; k < 4; k++) sk[i][k] = '0;
    end
    do_reset(2);

    // One word per VC, an invalid destination, then a dest-0 word.
    for (int i = 0; i < NI; i++) begin
      enqueue(i, 10'h000); enqueue(i, 10'h100); enqueue(i, 10'h200);
      enqueue(i, 10'h300); enqueue(i, 10'h0AB);
    end
    repeat (10) step();
    check("A.glob.disp", 32'(dc_g),  32'd4);
    check("A.glob.drop", 32'(drc_g), 32'd1);
    check("A.sel.disp",  32'(dc_s),  32'd4);
    check("A.sel.drop",  32'(drc_s), 32'd1);

    // Pause VC2 mid-stream, then release: nothing lost or duplicated.
    for (int i = 0; i < NI; i++) begin
      for (int k = 0; k < 10; k++) begin
        w = {2'(k % 3), 8'(k)};
        enqueue(i, w);
      end
    end
    repeat (3) step();
    pause_a = {3'b100, 3'b100};
    repeat (5) step();
    pause_a = '0;
    repeat (20) step();
    check("B.glob.disp", 32'(dc_g), 32'd14);
    check("B.sel.disp",  32'(dc_s), 32'd14);

    // Selective mode streams dest 0/2 past a paused VC1.
    pause_a = {3'b010, 3'b000};
    for (int i = 0; i < NI; i++) begin
      for (int k = 0; k < 8; k++) begin
        w = {((k % 2) != 0) ? 2'd2 : 2'd0, 8'(k)};
        enqueue(i, w);
      end
    end
    repeat (12) step();
    check("B2.glob.disp", 32'(dc_g), 32'd22);
    check("B2.sel.disp",  32'(dc_s), 32'd22);

    // Head-of-line block on VC1, reset while blocked, then release.
    pause_a = {3'b010, 3'b010};
    for (int i = 0; i < NI; i++) begin
      for (int k = 0; k < 4; k++) begin
        w = {2'd1, 8'(8'h40 + 8'(k))};
        enqueue(i, w);
      end
    end
    repeat (6) step();
    do_reset(2);
    pause_a = '0;
    repeat (12) step();
    check("C.glob.disp", 32'(dc_g),  32'd4);
    check("C.sel.disp",  32'(dc_s),  32'd2);
    check("C.glob.drop", 32'(drc_g), 32'd0);
    check("C.sel.drop",  32'(drc_s), 32'd0);

    // Random traffic and pauses, long enough to saturate both counters.
    for (int c = 0; c < 3000; c++) begin
      if (c == 1000) do_reset(1);
      for (int i = 0; i < NI; i++) begin
        if (($urandom_range(9) < 8) && ((mq_wr[i] - mq_rd[i]) < 16)) enqueue(i, DW'($urandom));
        pause_a[i] = ($urandom_range(3) == 0) ? NV'($urandom) : '0;
      end
      step();
    end
    pause_a = '0;
    repeat (40) step();
    check("D.glob.disp_sat", 32'(dc_g),  32'd255);
    check("D.glob.drop_sat", 32'(drc_g), 32'd255);
    check("D.sel.disp_sat",  32'(dc_s),  32'd255);
    check("D.sel.drop_sat",  32'(drc_s), 32'd255);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
